// File: rtl/issue_pkg.sv
// Shared definitions for the instruction issue unit: opcode values, field
// positions inside the 16-bit word, and the read-class decoder.
package issue_pkg;

  localparam int INSTR_W   = 16;
  localparam int FIELD_W   = 4;
  localparam int CODOP_LSB = 12;
  localparam int S4_LSB    = 8;
  localparam int S3_LSB    = 4;
  localparam int S2_LSB    = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_XORI = 4'h8;
  localparam logic [3:0] OP_SLLI = 4'h9;
  localparam logic [3:0] OP_SUBI = 4'hA;

  typedef enum logic [1:0] {RR, RI, NR} read_class_e;

  typedef enum logic {IDLE, READY} issue_state_e;

  // Which source fields an opcode reads from the register bank.
  function automatic read_class_e read_class(input logic [3:0] op);
    read_class_e rc;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:                rc = RR;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SUBI: rc = RI;
      default:                                              rc = NR;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view; storage is an array with
// no reset so it maps onto distributed RAM.
module sync_fifo
  import issue_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != FULL_CNT);
  assign do_pop  = pop && (count_q != '0);

  // Pointers are exactly PTR_W bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/instr_issue.sv
// Instruction issue unit: buffers loader words, issues one per tick into the
// ALU field registers, and stalls while a source has a write-back in flight.
module instr_issue
  import issue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WB_LAT = 2
) (
  input  logic                   CLK_50,
  input  logic                   RST,
  input  logic                   tick,
  input  logic                   in_valid,
  input  logic [15:0]            in_instr,
  output logic                   in_ready,
  output logic [3:0]             codop,
  output logic [3:0]             s4,
  output logic [3:0]             s3,
  output logic [3:0]             s2,
  output logic                   issue_valid,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [INSTR_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_nonempty;
  logic               push;
  logic               issue;

  logic [FIELD_W-1:0] head_codop, head_s4, head_s3, head_s2;
  read_class_e        head_class;
  logic               reads_s3, reads_s2;

  logic [WB_LAT-1:0]              sb_valid_q, sb_valid_d;
  logic [WB_LAT-1:0][FIELD_W-1:0] sb_dest_q, sb_dest_d;
  logic [WB_LAT-1:0]              slot_hit;
  logic                           hazard;

  issue_state_e       state_q, state_d;
  logic [INSTR_W-1:0] fields_q, fields_d;
  logic               issue_valid_q;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK_50),
    .rst   (RST),
    .push  (push),
    .pop   (issue),
    .wdata (in_instr),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign in_ready      = !fifo_full;
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (fifo_count != '0);

  assign head_codop = fifo_head[CODOP_LSB +: FIELD_W];
  assign head_s4    = fifo_head[S4_LSB +: FIELD_W];
  assign head_s3    = fifo_head[S3_LSB +: FIELD_W];
  assign head_s2    = fifo_head[S2_LSB +: FIELD_W];

  assign head_class = read_class(head_codop);
  assign reads_s3   = (head_class == RR);
  assign reads_s2   = (head_class != NR);

  // The oldest slot writes back on the very tick it retires, so on a tick it
  // no longer guards its register; this makes a dependent issue exactly
  // WB_LAT ticks after its producer.
  genvar gi;
  generate
    for (gi = 0; gi < WB_LAT; gi++) begin : g_slot
      localparam bit RETIRING = (gi == WB_LAT - 1);
      logic live;
      assign live = sb_valid_q[gi] && !(RETIRING && tick);
      assign slot_hit[gi] = live &&
                            ((reads_s3 && (sb_dest_q[gi] == head_s3)) ||
                             (reads_s2 && (sb_dest_q[gi] == head_s2)));
    end
  endgenerate

  assign hazard = fifo_nonempty && (|slot_hit);
  assign stall  = hazard;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (push) state_d = READY;
      end
      READY: begin
        issue = tick && !hazard;
        if (issue && !push && (fifo_count == CNT_W'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scoreboard advances on every tick, whether or not anything issued.
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_dest_d  = sb_dest_q;
    if (tick) begin
      for (int i = WB_LAT - 1; i > 0; i--) begin
        sb_valid_d[i] = sb_valid_q[i-1];
        sb_dest_d[i]  = sb_dest_q[i-1];
      end
      sb_valid_d[0] = issue;
      sb_dest_d[0]  = issue ? head_s4 : '0;
    end
  end

  always_comb begin
    fields_d = fields_q;
    if (issue) fields_d = fifo_head;
  end

  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      sb_valid_q    <= '0;
      sb_dest_q     <= '0;
      fields_q      <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sb_valid_q    <= sb_valid_d;
      sb_dest_q     <= sb_dest_d;
      fields_q      <= fields_d;
      issue_valid_q <= issue;
    end
  end

  assign codop       = fields_q[CODOP_LSB +: FIELD_W];
  assign s4          = fields_q[S4_LSB +: FIELD_W];
  assign s3          = fields_q[S3_LSB +: FIELD_W];
  assign s2          = fields_q[S2_LSB +: FIELD_W];
  assign issue_valid = issue_valid_q;
  assign count       = fifo_count;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed vector table, hand sequences
// for fill/wrap/reset, and random traffic against a queue-based model.
module tb_instr_issue;

  localparam int DEPTH  = 8;
  localparam int WB_LAT = 2;

  logic        CLK_50 = 1'b0;
  logic        RST = 1'b1;
  logic        tick = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic [3:0]  codop, s4, s3, s2;
  logic        issue_valid;
  logic        stall;
  logic [3:0]  count;

  always #5 CLK_50 = ~CLK_50;

  instr_issue #(
    .DEPTH  (DEPTH),
    .WB_LAT (WB_LAT)
  ) dut (
    .CLK_50      (CLK_50),
    .RST         (RST),
    .tick        (tick),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .codop       (codop),
    .s4          (s4),
    .s3          (s3),
    .s2          (s2),
    .issue_valid (issue_valid),
    .stall       (stall),
    .count       (count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending producers are remembered by the tick number on
  // which they issued; a producer guards its register until WB_LAT ticks on.
  logic [15:0] mq[$];
  int          prod_tick[$];
  logic [3:0]  prod_dest[$];
  int          ticks_done;
  logic [15:0] m_fields;
  bit          m_iv;
  logic        obs_stall, obs_iv;
  int          issued_n;

  task automatic model_reset();
    mq.delete();
    prod_tick.delete();
    prod_dest.delete();
    ticks_done = 0;
    m_fields   = '0;
    m_iv       = 1'b0;
  endtask

  function automatic bit blocked(input logic [15:0] w, input int tick_no);
    logic [3:0] op;
    bit rd2, rd3;
    op  = w[15:12];
    rd2 = (op <= 4'd10);
    rd3 = (op == 4'd0) || (op == 4'd1) || (op == 4'd3) || (op == 4'd4) || (op == 4'd5);
    for (int i = 0; i < prod_tick.size(); i++) begin
      if (tick_no - prod_tick[i] < WB_LAT) begin
        if ((rd3 && prod_dest[i] == w[7:4]) || (rd2 && prod_dest[i] == w[3:0])) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock cycle: entered and left at a falling edge.
  task automatic step(input bit t, input bit v, input logic [15:0] w);
    int tick_no;
    bit hz, iss, psh;
    tick = t;
    in_valid = v;
    in_instr = w;
    #1;
    tick_no = ticks_done + (t ? 1 : 0);
    hz = (mq.size() > 0) && blocked(mq[0], tick_no);
    chk("stall", 32'(stall), 32'(hz));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("count_pre", 32'(count), 32'(mq.size()));
    obs_stall = stall;
    iss = t && (mq.size() > 0) && !hz;
    psh = v && (mq.size() < DEPTH);
    if (iss) begin
      m_fields = mq.pop_front();
      prod_tick.push_back(tick_no);
      prod_dest.push_back(m_fields[11:8]);
    end
    m_iv = iss;
    if (psh) mq.push_back(w);
    if (t) ticks_done++;
    while (prod_tick.size() > 0 && ticks_done - prod_tick[0] >= WB_LAT) begin
      void'(prod_tick.pop_front());
      void'(prod_dest.pop_front());
    end
    @(posedge CLK_50);
    #1;
    chk("issue_valid", 32'(issue_valid), 32'(m_iv));
    chk("fields", 32'({codop, s4, s3, s2}), 32'(m_fields));
    chk("count", 32'(count), 32'(mq.size()));
    obs_iv = issue_valid;
    if (issue_valid === 1'b1) issued_n++;
    @(negedge CLK_50);
  endtask

  task automatic do_reset();
    tick = 1'b1;
    in_valid = 1'b0;
    RST = 1'b1;
    model_reset();
    @(negedge CLK_50);
    @(negedge CLK_50);
    RST = 1'b0;
    tick = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fields"}, 32'({codop, s4, s3, s2}), 32'h0);
    chk({tag, "_issue_valid"}, 32'(issue_valid), 32'h0);
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
  endtask

  typedef struct {
    bit          t;
    bit          v;
    logic [15:0] w;
    bit          e_stall;
    bit          e_iv;
    logic [15:0] e_fields;
    int          e_cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // basic issue, dependency stall, and immediate-form non-stall
    tbl[0]  = '{1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 16'h0000, 1};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0123, 0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0123, 0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0123, 0};
    tbl[4]  = '{1'b0, 1'b1, 16'h0512, 1'b0, 1'b0, 16'h0123, 1};
    tbl[5]  = '{1'b0, 1'b1, 16'h0653, 1'b0, 1'b0, 16'h0123, 2};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0512, 1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0512, 1};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0512, 1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0512, 1};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0653, 0};
    tbl[11] = '{1'b0, 1'b1, 16'h0512, 1'b0, 1'b0, 16'h0653, 1};
    tbl[12] = '{1'b0, 1'b1, 16'h6752, 1'b0, 1'b0, 16'h0653, 2};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0512, 1};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h6752, 0};

    issued_n = 0;
    model_reset();
    @(negedge CLK_50);
    #1;
    chk_reset_outputs("reset");
    @(negedge CLK_50);
    RST = 1'b0;
    tick = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].t, tbl[i].v, tbl[i].w);
      chk($sformatf("tbl%0d_stall", i), 32'(obs_stall), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_iv", i), 32'(obs_iv), 32'(tbl[i].e_iv));
      chk($sformatf("tbl%0d_fields", i), 32'({codop, s4, s3, s2}), 32'(tbl[i].e_fields));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
    end

    // Fill past capacity with no ticks, then free one slot.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'(16'hB000 + i));
    chk("fill_in_ready", 32'(in_ready), 32'h0);
    chk("fill_count", 32'(count), 32'h8);
    step(1'b1, 1'b1, 16'hBEEF);
    chk("fill_pop_count", 32'(count), 32'h7);
    chk("fill_pop_fields", 32'({codop, s4, s3, s2}), 32'hB000);
    chk("freed_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0);
    chk("fill_drained", 32'(count), 32'h0);

    // Continuous push and issue across several pointer wraps.
    do_reset();
    issued_n = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, {4'(11 + i % 5), 4'(i), 4'(i + 3), 4'(i + 7)});
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0);
    chk("wrap_issued", 32'(issued_n), 32'd20);

    // Reset with buffered words and a write-back still pending.
    do_reset();
    step(1'b0, 1'b1, 16'h0512);
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0153);
    step(1'b0, 1'b1, 16'h0253);
    step(1'b0, 1'b1, 16'h0353);
    chk("pre_reset_count", 32'(count), 32'h3);
    chk("pre_reset_stall", 32'(stall), 32'h1);
    RST = 1'b1;
    tick = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge CLK_50);
    RST = 1'b0;
    tick = 1'b0;
    step(1'b0, 1'b1, 16'h0653);
    step(1'b1, 1'b0, 16'h0);
    chk("post_reset_stall", 32'(obs_stall), 32'h0);
    chk("post_reset_iv", 32'(obs_iv), 32'h1);
    chk("post_reset_fields", 32'({codop, s4, s3, s2}), 32'h0653);

    // Random traffic, narrow register range to provoke hazards.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           {4'($urandom_range(0, 15)), 2'b00, 2'($urandom), 2'b00, 2'($urandom),
            2'b00, 2'($urandom)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
